// File: rtl/scaler_lcd_sink.sv
// LCD sink for the scaler output stream: buffers pixels in a show-ahead FIFO,
// generates fixed panel timing and centres smaller frames inside a black border.
module scaler_lcd_sink #(
  parameter int DATA_WIDTH = 16,
  parameter int RES_WIDTH  = 12,
  parameter int FIFO_AW    = 11,
  parameter int H_ACT      = 1024,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 160,
  parameter int V_ACT      = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 29,
  parameter logic [DATA_WIDTH-1:0] BLACK = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sDat,
  input  logic                  sEn,
  input  logic                  sHS,
  input  logic                  sVS,
  input  logic [RES_WIDTH-1:0]  actXRes,
  input  logic [RES_WIDTH-1:0]  actYRes,
  output logic                  lcdHs,
  output logic                  lcdVs,
  output logic                  lcdDe,
  output logic [DATA_WIDTH-1:0] lcdDat,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [RES_WIDTH-1:0] H_ACT_R  = RES_WIDTH'(H_ACT);
  localparam logic [RES_WIDTH-1:0] V_ACT_R  = RES_WIDTH'(V_ACT);
  localparam logic [RES_WIDTH-1:0] HS_START = RES_WIDTH'(H_ACT + H_FP);
  localparam logic [RES_WIDTH-1:0] HS_END   = RES_WIDTH'(H_ACT + H_FP + H_SYNC);
  localparam logic [RES_WIDTH-1:0] VS_START = RES_WIDTH'(V_ACT + V_FP);
  localparam logic [RES_WIDTH-1:0] VS_END   = RES_WIDTH'(V_ACT + V_FP + V_SYNC);
  localparam logic [RES_WIDTH-1:0] H_LAST   = RES_WIDTH'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [RES_WIDTH-1:0] V_LAST   = RES_WIDTH'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [FIFO_AW:0]     FULL_CNT = (FIFO_AW+1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  logic [RES_WIDTH-1:0]  hCnt, vCnt, xRes, yRes;
  logic [1:0]            state;
  logic                  sVsD, sVsQ, sHsD, sHsQ;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]    wrPtr, rdPtr;
  logic [FIFO_AW:0]      count;

  logic                  frameStart, vsRise, active, inWin;
  logic                  popReq, doPop, popUnder, doPush, pushOver, full, empty;
  logic [RES_WIDTH-1:0]  curX, curY, xOff, yOff;
  logic [RES_WIDTH:0]    xEnd, yEnd;

  // The frame size is latched at frame start but must already apply to that first cycle.
  assign frameStart = (hCnt == '0) && (vCnt == '0);
  assign curX       = frameStart ? actXRes : xRes;
  assign curY       = frameStart ? actYRes : yRes;
  assign xOff       = (H_ACT_R - curX) >> 1;
  assign yOff       = (V_ACT_R - curY) >> 1;
  assign xEnd       = {1'b0, xOff} + {1'b0, curX};
  assign yEnd       = {1'b0, yOff} + {1'b0, curY};
  assign active     = (hCnt < H_ACT_R) && (vCnt < V_ACT_R);
  assign inWin      = active && (hCnt >= xOff) && ({1'b0, hCnt} < xEnd)
                             && (vCnt >= yOff) && ({1'b0, vCnt} < yEnd);

  assign vsRise   = sVsD & ~sVsQ;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign popReq   = inWin && !vsRise && ((state == RUN) || (state == ARMED && frameStart));
  assign doPop    = popReq && !empty;
  assign popUnder = popReq && empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign doPush   = sEn && !vsRise && (!full || doPop);
  assign pushOver = sEn && !vsRise && full && !doPop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (hCnt == H_LAST) begin
      hCnt <= '0;
      vCnt <= (vCnt == V_LAST) ? '0 : vCnt + 1'b1;
    end else begin
      hCnt <= hCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sVsD <= 1'b0;
      sVsQ <= 1'b0;
      sHsD <= 1'b0;
      sHsQ <= 1'b0;
      xRes <= '0;
      yRes <= '0;
    end else begin
      sVsD <= sVS;
      sVsQ <= sVsD;
      sHsD <= sHS;
      sHsQ <= sHsD;
      if (frameStart) begin
        xRes <= actXRes;
        yRes <= actYRes;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= sDat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (vsRise) begin
        state <= ARMED;
        wrPtr <= '0;
        rdPtr <= '0;
        count <= '0;
      end else begin
        if (state == ARMED && frameStart) begin
          state     <= RUN;
          overflow  <= 1'b0;
          underflow <= 1'b0;
        end
        if (doPush) wrPtr <= wrPtr + 1'b1;
        if (doPop)  rdPtr <= rdPtr + 1'b1;
        count <= count + {{FIFO_AW{1'b0}}, doPush} - {{FIFO_AW{1'b0}}, doPop};
      end
      // Events in the transition cycle itself win over the clear above.
      if (pushOver) overflow  <= 1'b1;
      if (popUnder) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcdHs  <= 1'b1;
      lcdVs  <= 1'b1;
      lcdDe  <= 1'b0;
      lcdDat <= BLACK;
    end else begin
      lcdHs  <= !((hCnt >= HS_START) && (hCnt < HS_END));
      lcdVs  <= !((vCnt >= VS_START) && (vCnt < VS_END));
      lcdDe  <= active;
      lcdDat <= doPop ? mem[rdPtr] : BLACK;
    end
  end

endmodule

// File: tb/tb_scaler_lcd_sink.sv
// Bench for scaler_lcd_sink on a shrunken panel (16x8 active, 24x13 total, 32-deep FIFO),
// checked cycle by cycle against a queue-based model of the panel timing and FIFO rules.
module tb_scaler_lcd_sink;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sDat;
  logic        sEn, sHS, sVS;
  logic [11:0] actXRes, actYRes;
  logic        lcdHs, lcdVs, lcdDe, overflow, underflow;
  logic [15:0] lcdDat;

  scaler_lcd_sink #(
    .DATA_WIDTH(16), .RES_WIDTH(12), .FIFO_AW(5),
    .H_ACT(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACT(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .BLACK(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .sDat(sDat), .sEn(sEn), .sHS(sHS), .sVS(sVS),
    .actXRes(actXRes), .actYRes(actYRes),
    .lcdHs(lcdHs), .lcdVs(lcdVs), .lcdDe(lcdDe), .lcdDat(lcdDat),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: cycle index since reset, mode 0=idle 1=armed 2=run
  int          t;
  int          mode;
  logic [15:0] q[$];
  logic        vsHist1, vsHist2;
  int          xr, yr;
  logic        ovf, unf;
  logic [15:0] ramp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; mode = 0; q.delete();
    vsHist1 = 1'b0; vsHist2 = 1'b0;
    xr = 0; yr = 0; ovf = 1'b0; unf = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hs"},  {31'd0, lcdHs},     32'd1);
    check({tag, "_vs"},  {31'd0, lcdVs},     32'd1);
    check({tag, "_de"},  {31'd0, lcdDe},     32'd0);
    check({tag, "_dat"}, {16'd0, lcdDat},    32'd0);
    check({tag, "_ovf"}, {31'd0, overflow},  32'd0);
    check({tag, "_unf"}, {31'd0, underflow}, 32'd0);
  endtask

  // One clock: predict outputs from the position in the frame and the FIFO contents.
  task automatic step();
    int h, v, xo, yo;
    bit fs, rise, act, win;
    logic eHs, eVs, eDe;
    logic [15:0] eDat;
    h  = t % HT;
    v  = (t / HT) % VT;
    fs = (h == 0) && (v == 0);
    if (fs) begin
      xr = int'(actXRes);
      yr = int'(actYRes);
    end
    rise = vsHist1 && !vsHist2;
    act  = (h < HA) && (v < VA);
    xo   = (HA - xr) / 2;
    yo   = (VA - yr) / 2;
    win  = act && (h >= xo) && (h < xo + xr) && (v >= yo) && (v < yo + yr);
    eDe  = act;
    eHs  = !((h >= HA + HFP) && (h < HA + HFP + HSW));
    eVs  = !((v >= VA + VFP) && (v < VA + VFP + VSW));
    eDat = 16'h0000;
    if (rise) begin
      q.delete();
      mode = 1;
    end else begin
      if (mode == 1 && fs) begin
        mode = 2; ovf = 1'b0; unf = 1'b0;
      end
      if (mode == 2 && win) begin
        if (q.size() > 0) eDat = q.pop_front();
        else unf = 1'b1;
      end
      if (sEn) begin
        if (q.size() < DEPTH) q.push_back(sDat);
        else ovf = 1'b1;
      end
    end
    vsHist2 = vsHist1;
    vsHist1 = sVS;
    t++;
    @(posedge clk); #1;
    check("hs",  {31'd0, lcdHs},     {31'd0, eHs});
    check("vs",  {31'd0, lcdVs},     {31'd0, eVs});
    check("de",  {31'd0, lcdDe},     {31'd0, eDe});
    check("dat", {16'd0, lcdDat},    {16'd0, eDat});
    check("ovf", {31'd0, overflow},  {31'd0, ovf});
    check("unf", {31'd0, underflow}, {31'd0, unf});
  endtask

  // kind: 0 ramp, 1 white, 2 random
  task automatic cycles(input int n, input int pct, input int kind);
    for (int i = 0; i < n; i++) begin
      sEn = ($urandom_range(99) < pct);
      if (kind == 0)      sDat = ramp;
      else if (kind == 1) sDat = 16'hFFFF;
      else                sDat = 16'($urandom);
      if (sEn && kind == 0) ramp = ramp + 16'd1;
      sHS = ((t % HT) < 2);
      step();
    end
    sEn = 1'b0;
  endtask

  task automatic vs_pulse();
    sVS = 1'b1;
    cycles(3, 0, 2);
    sVS = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sDat = '0; sEn = 1'b0; sHS = 1'b0; sVS = 1'b0;
    actXRes = 12'd16; actYRes = 12'd8; ramp = 16'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    $display("txn reset: outputs at reset values");

    cycles(FT, 0, 2);
    $display("txn sync: idle frame, panel timing only");

    vs_pulse();
    cycles(3 * FT, 45, 0);
    $display("txn full: 16x8 ramp frames, errors so far %0d", errors);

    actXRes = 12'd8; actYRes = 12'd4;
    cycles(37, 30, 1);
    vs_pulse();
    cycles(2 * FT, 30, 1);
    $display("txn centred: 8x4 white frames with mid-frame resync, errors so far %0d", errors);

    cycles(FT + 20, 0, 2);
    vs_pulse();
    cycles(FT, 40, 2);
    $display("txn underflow: starved frame then recovery, errors so far %0d", errors);

    actXRes = 12'd16; actYRes = 12'd8;
    cycles((FT + 2 - (t % FT)) % FT, 0, 2);
    vs_pulse();
    cycles(DEPTH + 8, 100, 0);
    cycles(FT, 0, 2);
    $display("txn overflow: %0d pushes while armed, errors so far %0d", DEPTH + 8, errors);

    cycles((FT + 10 - (t % FT)) % FT, 0, 2);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cycles(FT, 0, 2);
    $display("txn midreset: async reset mid-line then clean restart, errors so far %0d", errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
